// File: rtl/debug_settings_loader_pkg.sv
// Shared definitions for the debug GPIO path: channel type codes and the
// settings bundle handed from the loader to the multiplexer.
package params;
    localparam logic [7:0] DBG_NONE    = 8'h00;
    localparam logic [7:0] DBG_CONST   = 8'h01;
    localparam logic [7:0] DBG_PWM_OUT = 8'h02;
    localparam logic [7:0] DBG_PWM_IN  = 8'h03;
    localparam logic [7:0] DBG_GPIO_IN = 8'h04;

    localparam int DBG_WORDS_PER_CH = 4;
    localparam int DBG_NUM_CH       = 4;

    // The type code lives in the top byte of every channel word.
    function automatic logic [7:0] dbg_type(input logic [63:0] value);
        return value[63:56];
    endfunction
endpackage

package settings;
    import params::*;

    typedef struct packed {
        logic [DBG_NUM_CH-1:0][63:0] value;
    } debug_settings_t;
endpackage

// File: rtl/debug_value_sanitizer.sv
// Combinational check of one debug channel word: a PWM-output selection whose
// index is outside the implemented outputs is forced to DBG_NONE (all zero).
module debug_value_sanitizer
    import params::*;
#(
    parameter int unsigned DEPTH = 249
) (
    input  logic [63:0] i_value,
    output logic [63:0] o_value
);
    logic w_bad_pwm;

    assign w_bad_pwm = (dbg_type(i_value) == DBG_PWM_OUT) && (32'(i_value[7:0]) >= DEPTH);
    assign o_value   = w_bad_pwm ? '0 : i_value;
endmodule

// File: rtl/debug_settings_loader.sv
// Fetches the four 64-bit debug channel words from the controller BRAM,
// sanitizes them and commits all four channels on a single clock edge.
module debug_settings_loader
    import params::*;
    import settings::*;
#(
    parameter int unsigned DEPTH        = 249,
    parameter logic [8:0]  BASE_ADDR    = 9'h000,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            UPDATE,
    output logic            BRAM_EN,
    output logic [8:0]      BRAM_ADDR,
    input  logic [15:0]     BRAM_DOUT,
    output debug_settings_t DEBUG_SETTINGS,
    output logic            BUSY,
    output logic            DONE
);
    localparam int NUM_WORDS = DBG_NUM_CH * DBG_WORDS_PER_CH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_COMMIT
    } state_t;

    state_t                      r_state;
    logic                        r_pending;
    logic [3:0]                  r_issue_idx;
    logic [READ_LATENCY-1:0]     r_vld_sr;
    logic [3:0]                  r_idx_sr [READ_LATENCY];
    logic [DBG_NUM_CH-1:0][63:0] r_shadow;
    logic [DBG_NUM_CH-1:0][63:0] w_clean;
    logic                        w_capture;
    logic [3:0]                  w_cap_idx;
    logic                        w_last_capture;

    assign w_capture      = r_vld_sr[READ_LATENCY-1];
    assign w_cap_idx      = r_idx_sr[READ_LATENCY-1];
    assign w_last_capture = w_capture && (w_cap_idx == 4'(NUM_WORDS - 1));

    // Valid flags follow each issued read through the BRAM pipeline.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_vld_sr <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                r_vld_sr[i] <= r_vld_sr[i-1];
            end
            r_vld_sr[0] <= BRAM_EN;
        end
    end

    // NOTE: index and shadow registers carry data only; they are qualified by
    // the reset-cleared valid flags, so they need no reset of their own.
    always_ff @(posedge CLK) begin
        for (int i = READ_LATENCY - 1; i > 0; i--) begin
            r_idx_sr[i] <= r_idx_sr[i-1];
        end
        r_idx_sr[0] <= r_issue_idx;
        if (w_capture) begin
            r_shadow[w_cap_idx[3:2]][{w_cap_idx[1:0], 4'b0000} +: 16] <= BRAM_DOUT;
        end
    end

    for (genvar g = 0; g < DBG_NUM_CH; g++) begin : g_sanitize
        debug_value_sanitizer #(
            .DEPTH(DEPTH)
        ) u_sanitizer (
            .i_value(r_shadow[g]),
            .o_value(w_clean[g])
        );
    end

    // NOTE: every state and output register is assigned with <= so all of
    // them see the pre-edge values of each other, exactly like the flops.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= S_IDLE;
            r_pending      <= 1'b0;
            r_issue_idx    <= '0;
            BRAM_EN        <= 1'b0;
            BRAM_ADDR      <= '0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            DEBUG_SETTINGS <= '0;
        end else begin
            DONE <= 1'b0;
            if (UPDATE && r_state != S_IDLE) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (UPDATE || r_pending) begin
                        r_state     <= S_ISSUE;
                        r_pending   <= 1'b0;
                        BUSY        <= 1'b1;
                        BRAM_EN     <= 1'b1;
                        BRAM_ADDR   <= BASE_ADDR;
                        r_issue_idx <= '0;
                    end else begin
                        BUSY <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (r_issue_idx == 4'(NUM_WORDS - 1)) begin
                        BRAM_EN <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_issue_idx <= r_issue_idx + 4'd1;
                        BRAM_ADDR   <= BRAM_ADDR + 9'd1;
                    end
                end
                S_DRAIN: begin
                    if (w_last_capture) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // BUSY is held through the DONE cycle and drops in IDLE.
                    DEBUG_SETTINGS.value <= w_clean;
                    DONE                 <= 1'b1;
                    r_state              <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
